clk_enable_gen: RTL and testbench
=================================

# clk_enable_gen

Parametrised pipeline timing generator for the five-stage core. It replaces the fixed free-running PLL-clock divider with N independent, runtime-programmable divide channels, each producing single-cycle clock-enable ticks. It adds halt and single-step modes for board bring-up. It sits between the PLL and the Fetch/Decode/Execute/Memory/Writeback stages, which run on the fast clock and are gated by the channel-0 tick.

## Interface
- `CNT_WIDTH`, default 32: width of the divide counters and divide registers.
- `NUM_CH`, default 2: number of divide channels (1..8).
- `DEFAULT_DIV`, default 100000: divide value loaded into every channel at reset.
- `I_CLOCK`, in, 1: PLL output clock; the single clock domain.
- `I_RESET`, in, 1: asynchronous, active-high reset.
- `I_LOCK`, in, 1: raw PLL locked flag, asynchronous to `I_CLOCK`.
- `I_Mode`, in, 2: 00 halt, 01 run, 10 step, 11 treated as halt.
- `I_StepReq`, in, 1: step request level, synchronous; its rising edge is used.
- `I_DivLoad`, in, 1: one-cycle strobe that writes `I_DivValue` to channel `I_DivChan`.
- `I_DivChan`, in, 3: channel index; indices ≥ NUM_CH are ignored.
- `I_DivValue`, in, CNT_WIDTH: new divide value.
- `O_LOCK`, out, 1: synchronised lock, which gates the pipeline.
- `O_Tick`, out, NUM_CH: per-channel one-cycle enable pulse.
- `O_SlowClk`, out, NUM_CH: per-channel square wave, toggled on each tick (LED/legacy use).
- `O_State`, out, 2: 00 WAIT_LOCK, 01 RUN, 10 HALT, 11 STEP.
- `O_TickCount`, out, 32: number of channel-0 ticks since lock; wraps modulo 2^32.

## Operation
- **Lock synchroniser.** Two-flop synchroniser on `I_LOCK`; `O_LOCK` is the second flop.
- **State machine.**
  - WAIT_LOCK → RUN/HALT/STEP according to `I_Mode`, on the first edge where `O_LOCK` = 1.
  - Among RUN/HALT/STEP, the next state follows `I_Mode` every cycle.
  - From any state, `O_LOCK` = 0 → WAIT_LOCK.
- **WAIT_LOCK.**
  - All counters and `O_SlowClk` are cleared; `O_Tick` = 0; `O_TickCount` is cleared.
  - Divide registers keep their values.
- **RUN, channel c.**
  - The counter increments each cycle.
  - When counter == div[c]: counter ← 0, `O_Tick[c]` = 1 in the following cycle, `O_SlowClk[c]` toggles.
  - Tick period = div[c]+1 cycles. div = 0 gives a tick every cycle, and SlowClk then toggles every cycle.
- **HALT.**
  - Counters are frozen, `O_Tick` = 0, `O_SlowClk` holds its value.
  - Step requests are ignored.
- **STEP.**
  - Counters are frozen.
  - Each rising edge of `I_StepReq` produces one tick on all channels in the next cycle. Each step also toggles SlowClk and adds 1 to `O_TickCount`.
  - The edge detector is updated in every state. A request held high while entering STEP therefore produces no tick until it falls and rises again.
- **Divide load.**
  - `I_DivLoad` writes div[`I_DivChan`] and clears that channel's counter in the same edge, in any state including WAIT_LOCK.
  - A load coinciding with a terminal count wins: no tick, counter = 0.
  - SlowClk phase is unaffected.
- **Tick counter.** `O_TickCount` increments on every cycle where `O_Tick[0]` = 1; it wraps from 0xFFFFFFFF to 0.
- **Widths.** Comparisons are unsigned and full CNT_WIDTH. `I_DivValue` is taken as-is.

## Timing
- **Reset values.** `I_RESET` asserted, at any time including mid-count:
  - `O_LOCK` = 0, `O_Tick` = 0, `O_SlowClk` = 0, `O_State` = 00, `O_TickCount` = 0.
  - Counters = 0; all div registers = DEFAULT_DIV; edge detector = 0.
- **Lock latency.** `I_LOCK` rises → `O_LOCK` is high after the 2nd `I_CLOCK` rising edge → `O_State` leaves WAIT_LOCK at the 3rd edge.
- **First tick.** The first RUN tick appears div+1 cycles after entering RUN; the counter starts at 0 in the entry cycle.
- **Registered outputs.** `O_Tick` is registered, so pulses are exactly 1 cycle wide and never back-to-back except when div = 0.
- **Lock loss.** Lock loss mid-count: WAIT_LOCK is entered 2 edges after `I_LOCK` falls. Any tick that was due is suppressed.
- **Mode changes.** Mode changes take effect at the next edge. A tick already registered still appears in the following cycle.

## Test plan
- **Reset and lock.** Reset, then `I_LOCK` = 1, mode 01, DEFAULT_DIV overridden to 3 on ch0 → `O_LOCK` high after edge 2; ticks every 4 cycles; `O_SlowClk[0]` period 8; `O_TickCount` = 5 after 5 ticks.
- **Independent channels.** ch0 div = 1, ch1 div = 4 in RUN → ch0 tick every 2 cycles, ch1 every 5; pulses are 1 cycle wide.
- **Halt and step.**
  - RUN with div = 9 → switch to HALT mid-count → no ticks.
  - STEP → 3 `I_StepReq` pulses give exactly 3 ticks on every channel, `O_TickCount` += 3.
  - Holding `I_StepReq` high across entry into STEP gives 0 ticks.
- **Load at terminal count.** div = 2, `I_DivLoad` with value 5 on the terminal-count cycle → no tick; next tick 6 cycles later.
- **Lock drop and reset.**
  - `I_LOCK` drops mid-count → `O_State` = 00 after 2 edges; `O_Tick` = 0, `O_SlowClk` = 0, `O_TickCount` = 0; div registers retained.
  - Async `I_RESET` pulse between edges → all outputs 0 immediately.
- **Tick counter wrap.** Force `O_TickCount` to 0xFFFFFFFE (via hierarchical force), div = 0 → reads 0xFFFFFFFF, then 0x00000000.

Source files
------------

// File: rtl/clk_enable_gen_if.sv
// Control/status bundle between the pipeline timing generator and its controller.
interface clk_enable_gen_if #(
    parameter int unsigned CNT_WIDTH = 32,
    parameter int unsigned NUM_CH    = 2
);
    logic                 I_LOCK;
    logic [1:0]           I_Mode;
    logic                 I_StepReq;
    logic                 I_DivLoad;
    logic [2:0]           I_DivChan;
    logic [CNT_WIDTH-1:0] I_DivValue;
    logic                 O_LOCK;
    logic [NUM_CH-1:0]    O_Tick;
    logic [NUM_CH-1:0]    O_SlowClk;
    logic [1:0]           O_State;
    logic [31:0]          O_TickCount;

    modport master (
        output I_LOCK, I_Mode, I_StepReq, I_DivLoad, I_DivChan, I_DivValue,
        input  O_LOCK, O_Tick, O_SlowClk, O_State, O_TickCount
    );

    modport slave (
        input  I_LOCK, I_Mode, I_StepReq, I_DivLoad, I_DivChan, I_DivValue,
        output O_LOCK, O_Tick, O_SlowClk, O_State, O_TickCount
    );
endinterface

// File: rtl/clk_enable_gen.sv
// Pipeline timing generator: NUM_CH programmable clock-enable divide channels with
// halt / single-step control, gated by a synchronised PLL lock.
module clk_enable_gen #(
    parameter int unsigned CNT_WIDTH   = 32,
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DEFAULT_DIV = 100000
) (
    input  logic            I_CLOCK,
    input  logic            I_RESET,
    clk_enable_gen_if.slave bus
);

    typedef enum logic [1:0] {
        StWaitLock = 2'b00,
        StRun      = 2'b01,
        StHalt     = 2'b10,
        StStep     = 2'b11
    } state_e;

    typedef logic [CNT_WIDTH-1:0] cnt_t;

    state_e            state_q, state_d, mode_state;
    logic              lock_meta_q, lock_sync_q;
    logic              step_q, step_rise;
    logic              load_hit;
    cnt_t              cnt_q [NUM_CH];
    cnt_t              cnt_d [NUM_CH];
    cnt_t              div_q [NUM_CH];
    cnt_t              div_d [NUM_CH];
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] slow_q, slow_d;
    logic [31:0]       tick_count_q, tick_count_d;

    always_comb begin
        unique case (bus.I_Mode)
            2'b01:   mode_state = StRun;
            2'b10:   mode_state = StStep;
            default: mode_state = StHalt;
        endcase
        // Leave the run states on the same edge O_LOCK falls, so a due tick is dropped.
        state_d      = (lock_meta_q && lock_sync_q) ? mode_state : StWaitLock;
        step_rise    = bus.I_StepReq & ~step_q;
        cnt_d        = cnt_q;
        div_d        = div_q;
        tick_d       = '0;
        slow_d       = slow_q;
        load_hit     = 1'b0;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            load_hit = bus.I_DivLoad && (bus.I_DivChan == 3'(c));
            unique case (state_q)
                StRun: begin
                    if (cnt_q[c] == div_q[c]) begin
                        cnt_d[c]  = '0;
                        tick_d[c] = 1'b1;
                    end else begin
                        cnt_d[c] = cnt_q[c] + cnt_t'(1);
                    end
                end
                StStep:  tick_d[c] = step_rise;
                default: ;
            endcase
            // A load beats a coinciding terminal count.
            if (load_hit) begin
                div_d[c] = bus.I_DivValue;
                cnt_d[c] = '0;
                if (state_q == StRun) tick_d[c] = 1'b0;
            end
            if (tick_d[c]) slow_d[c] = ~slow_q[c];
            if (state_d == StWaitLock) begin
                cnt_d[c]  = '0;
                tick_d[c] = 1'b0;
                slow_d[c] = 1'b0;
            end
        end
        tick_count_d = tick_q[0] ? tick_count_q + 32'd1 : tick_count_q;
        if (state_d == StWaitLock) tick_count_d = '0;
    end

    always_ff @(posedge I_CLOCK or posedge I_RESET) begin
        if (I_RESET) begin
            state_q      <= StWaitLock;
            lock_meta_q  <= 1'b0;
            lock_sync_q  <= 1'b0;
            step_q       <= 1'b0;
            tick_q       <= '0;
            slow_q       <= '0;
            tick_count_q <= '0;
            for (int c = 0; c < int'(NUM_CH); c++) begin
                cnt_q[c] <= '0;
                div_q[c] <= cnt_t'(DEFAULT_DIV);
            end
        end else begin
            state_q      <= state_d;
            lock_meta_q  <= bus.I_LOCK;
            lock_sync_q  <= lock_meta_q;
            step_q       <= bus.I_StepReq;
            tick_q       <= tick_d;
            slow_q       <= slow_d;
            tick_count_q <= tick_count_d;
            cnt_q        <= cnt_d;
            div_q        <= div_d;
        end
    end

    assign bus.O_LOCK      = lock_sync_q;
    assign bus.O_Tick      = tick_q;
    assign bus.O_SlowClk   = slow_q;
    assign bus.O_State     = state_q;
    assign bus.O_TickCount = tick_count_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Bench for clk_enable_gen: tick-time scoreboard plus a table of divide settings.
module tb_clk_enable_gen;
    localparam int unsigned CW   = 16;
    localparam int unsigned NC   = 2;
    localparam int unsigned DDIV = 7;

    typedef struct {
        int d0;
        int d1;
        int w;
        int n0;
        int n1;
        int dcnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    int   exp_q0[$];
    int   exp_q1[$];
    int   seen[2];
    vec_t vecs[4];

    clk_enable_gen_if #(.CNT_WIDTH(CW), .NUM_CH(NC)) bus ();

    clk_enable_gen #(
        .CNT_WIDTH  (CW),
        .NUM_CH     (NC),
        .DEFAULT_DIV(DDIV)
    ) dut (
        .I_CLOCK(clk),
        .I_RESET(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every observed tick must match the next expected tick time.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.O_Tick[0]) begin
                seen[0]++;
                if (exp_q0.size() == 0) check("tick0_extra", 32'(bus.O_Tick[0]), 32'd0);
                else check("tick0_time", cyc, exp_q0.pop_front());
            end
            if (bus.O_Tick[1]) begin
                seen[1]++;
                if (exp_q1.size() == 0) check("tick1_extra", 32'(bus.O_Tick[1]), 32'd0);
                else check("tick1_time", cyc, exp_q1.pop_front());
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_ticks(input int e, input int d0, input int d1, input int w);
        for (int t = e + d0 + 1; t <= e + w; t += d0 + 1) exp_q0.push_back(t);
        for (int t = e + d1 + 1; t <= e + w; t += d1 + 1) exp_q1.push_back(t);
    endtask

    task automatic load_div(input int ch, input int val);
        bus.I_DivLoad  = 1'b1;
        bus.I_DivChan  = 3'(ch);
        bus.I_DivValue = CW'(val);
        cycles(1);
        bus.I_DivLoad  = 1'b0;
    endtask

    task automatic end_window(input string tag);
        check({tag, "_missing0"}, exp_q0.size(), 32'd0);
        check({tag, "_missing1"}, exp_q1.size(), 32'd0);
        mon_en = 1'b0;
        exp_q0.delete();
        exp_q1.delete();
    endtask

    task automatic clear_seen();
        seen[0] = 0;
        seen[1] = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int h;
        logic [31:0] c0;

        vecs[0] = '{1, 4, 21, 10, 4, 10};
        vecs[1] = '{0, 2, 9, 9, 3, 8};
        vecs[2] = '{5, 0, 13, 2, 13, 2};
        vecs[3] = '{2, 3, 12, 4, 3, 3};

        bus.I_LOCK = 1'b0;
        bus.I_Mode = 2'b01;
        bus.I_StepReq = 1'b0;
        bus.I_DivLoad = 1'b0;
        bus.I_DivChan = 3'd0;
        bus.I_DivValue = '0;
        clear_seen();

        // Reset state
        cycles(2);
        check("rst_lock", 32'(bus.O_LOCK), 32'd0);
        check("rst_tick", 32'(bus.O_Tick), 32'd0);
        check("rst_slow", 32'(bus.O_SlowClk), 32'd0);
        check("rst_state", 32'(bus.O_State), 32'd0);
        check("rst_count", bus.O_TickCount, 32'd0);
        rst = 1'b0;

        // Lock-up with ch0 div 3, ch1 left at the default
        load_div(0, 3);
        bus.I_LOCK = 1'b1;
        cycles(1);
        check("lock_edge1", 32'(bus.O_LOCK), 32'd0);
        cycles(1);
        check("lock_edge2", 32'(bus.O_LOCK), 32'd1);
        check("state_edge2", 32'(bus.O_State), 32'd0);
        cycles(1);
        check("state_edge3", 32'(bus.O_State), 32'd1);
        e = cyc;
        push_ticks(e, 3, DDIV, 21);
        clear_seen();
        mon_en = 1'b1;
        for (int k = 1; k <= 21; k++) begin
            cycles(1);
            if (k == 4 || k == 7) check("slow0_high", 32'(bus.O_SlowClk[0]), 32'd1);
            if (k == 8 || k == 11) check("slow0_low", 32'(bus.O_SlowClk[0]), 32'd0);
            if (k == 8) check("slow1_high", 32'(bus.O_SlowClk[1]), 32'd1);
        end
        check("count_after5", bus.O_TickCount, 32'd5);
        check("lockup_n0", seen[0], 32'd5);
        check("lockup_n1", seen[1], 32'd2);
        end_window("lockup");

        // Independent channel divide table
        for (int i = 0; i < 4; i++) begin
            bus.I_Mode = (i % 2 == 0) ? 2'b00 : 2'b11;
            cycles(2);
            check("row_halt_state", 32'(bus.O_State), 32'd2);
            load_div(0, vecs[i].d0);
            load_div(1, vecs[i].d1);
            bus.I_Mode = 2'b01;
            cycles(1);
            check("row_run_state", 32'(bus.O_State), 32'd1);
            e = cyc;
            c0 = bus.O_TickCount;
            clear_seen();
            push_ticks(e, vecs[i].d0, vecs[i].d1, vecs[i].w);
            mon_en = 1'b1;
            cycles(vecs[i].w);
            check("row_n0", seen[0], vecs[i].dcnt == 0 ? 32'd0 : 32'(vecs[i].n0));
            check("row_n1", seen[1], 32'(vecs[i].n1));
            check("row_count", bus.O_TickCount - c0, 32'(vecs[i].dcnt));
            end_window("row");
        end

        // Halt mid-count freezes counters and ticks
        bus.I_Mode = 2'b00;
        cycles(2);
        load_div(0, 9);
        load_div(1, 9);
        bus.I_Mode = 2'b01;
        cycles(1);
        clear_seen();
        mon_en = 1'b1;
        cycles(5);
        bus.I_Mode = 2'b00;
        cycles(20);
        check("halt_n0", seen[0], 32'd0);
        check("halt_n1", seen[1], 32'd0);
        check("halt_state", 32'(bus.O_State), 32'd2);
        // Counter froze at 6: tick 5 cycles after resuming
        bus.I_Mode = 2'b01;
        h = cyc;
        exp_q0.push_back(h + 5);
        exp_q1.push_back(h + 5);
        cycles(6);

        // Single step
        bus.I_Mode = 2'b10;
        cycles(2);
        check("step_state", 32'(bus.O_State), 32'd3);
        c0 = bus.O_TickCount;
        clear_seen();
        for (int p = 0; p < 3; p++) begin
            bus.I_StepReq = 1'b1;
            exp_q0.push_back(cyc + 1);
            exp_q1.push_back(cyc + 1);
            cycles(1);
            bus.I_StepReq = 1'b0;
            cycles(2);
        end
        check("step_n0", seen[0], 32'd3);
        check("step_n1", seen[1], 32'd3);
        check("step_count", bus.O_TickCount, c0 + 32'd3);

        // Request held high across entry into STEP
        bus.I_Mode = 2'b00;
        cycles(1);
        bus.I_StepReq = 1'b1;
        cycles(2);
        bus.I_Mode = 2'b10;
        cycles(4);
        check("held_n0", seen[0], 32'd3);
        check("held_n1", seen[1], 32'd3);
        bus.I_StepReq = 1'b0;
        cycles(1);
        bus.I_StepReq = 1'b1;
        exp_q0.push_back(cyc + 1);
        exp_q1.push_back(cyc + 1);
        cycles(1);
        bus.I_StepReq = 1'b0;
        cycles(2);
        check("repress_n0", seen[0], 32'd4);
        end_window("step");

        // Lock drop with a tick due on the WAIT_LOCK edge
        bus.I_Mode = 2'b00;
        cycles(2);
        load_div(0, 3);
        load_div(1, 9);
        bus.I_Mode = 2'b01;
        cycles(1);
        e = cyc;
        exp_q0.push_back(e + 4);
        mon_en = 1'b1;
        cycles(6);
        bus.I_LOCK = 1'b0;
        cycles(1);
        check("drop_edge1_state", 32'(bus.O_State), 32'd1);
        check("drop_edge1_lock", 32'(bus.O_LOCK), 32'd1);
        cycles(1);
        check("drop_state", 32'(bus.O_State), 32'd0);
        check("drop_lock", 32'(bus.O_LOCK), 32'd0);
        check("drop_tick", 32'(bus.O_Tick), 32'd0);
        check("drop_slow", 32'(bus.O_SlowClk), 32'd0);
        check("drop_count", bus.O_TickCount, 32'd0);
        cycles(2);

        // Relock: divide registers were retained
        bus.I_LOCK = 1'b1;
        cycles(3);
        check("relock_state", 32'(bus.O_State), 32'd1);
        e = cyc;
        exp_q0.push_back(e + 4);
        cycles(5);
        bus.I_LOCK = 1'b0;
        cycles(2);
        check("redrop_state", 32'(bus.O_State), 32'd0);
        end_window("relock");

        // Load on the terminal-count cycle
        load_div(0, 2);
        load_div(1, 50);
        bus.I_LOCK = 1'b1;
        cycles(3);
        e = cyc;
        exp_q0.push_back(e + 3);
        exp_q0.push_back(e + 12);
        mon_en = 1'b1;
        cycles(5);
        load_div(0, 5);
        check("load_slow_hold", 32'(bus.O_SlowClk[0]), 32'd1);
        cycles(5);
        check("load_slow_hold2", 32'(bus.O_SlowClk[0]), 32'd1);
        cycles(1);
        check("load_slow_toggle", 32'(bus.O_SlowClk[0]), 32'd0);
        cycles(1);
        end_window("load_tc");

        // Asynchronous reset between edges
        cycles(6);
        #2;
        rst = 1'b1;
        #1;
        check("arst_lock", 32'(bus.O_LOCK), 32'd0);
        check("arst_tick", 32'(bus.O_Tick), 32'd0);
        check("arst_slow", 32'(bus.O_SlowClk), 32'd0);
        check("arst_state", 32'(bus.O_State), 32'd0);
        check("arst_count", bus.O_TickCount, 32'd0);
        cycles(1);
        rst = 1'b0;

        // Tick counter wrap with a tick every cycle
        load_div(0, 0);
        cycles(4);
        check("wrap_tick", 32'(bus.O_Tick[0]), 32'd1);
        force dut.tick_count_q = 32'hFFFF_FFFE;
        #1;
        release dut.tick_count_q;
        check("wrap_forced", bus.O_TickCount, 32'hFFFF_FFFE);
        cycles(1);
        check("wrap_max", bus.O_TickCount, 32'hFFFF_FFFF);
        cycles(1);
        check("wrap_zero", bus.O_TickCount, 32'h0000_0000);
        cycles(1);
        check("wrap_one", bus.O_TickCount, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
